// File: rtl/ceyloniac_regfile_pkg.sv
// Shared register-file types and defaults used by the writeback arbiter and
// round-robin arbiter.
package ceyloniac_regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  localparam logic [DEFAULT_ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [DEFAULT_ADDR_WIDTH-1:0] addr;
    logic [DEFAULT_DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/ceyloniac_rr_arbiter.sv
// Combinational round-robin arbiter: scan starts one past last_grant and the
// first asserted request wins a one-hot grant.
module ceyloniac_rr_arbiter
  import ceyloniac_regfile_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant
);

  logic found;

  // Outer loop walks priority order, inner loop keeps every bit index constant.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (i == ((int'(last_grant) + k) % NUM_REQ))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ceyloniac_regfile_wb_arbiter.sv
// Register-file writeback port sharing with a per-register busy scoreboard.
// Optional forwarding outputs are enabled by defining CEYLONIAC_WB_BYPASS_EN.
module ceyloniac_regfile_wb_arbiter
  import ceyloniac_regfile_pkg::*;
#(
  parameter int REG_DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_REQ        = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*REG_DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               rf_write_enable,
  output logic [REG_ADDR_WIDTH-1:0]          rf_write_addr,
  output logic [REG_DATA_WIDTH-1:0]          rf_write_data,
  input  logic                               rsv_valid,
  input  logic [REG_ADDR_WIDTH-1:0]          rsv_addr,
  input  logic [REG_ADDR_WIDTH-1:0]          query_addr1,
  input  logic [REG_ADDR_WIDTH-1:0]          query_addr2,
  output logic                               query_busy1,
  output logic                               query_busy2
`ifdef CEYLONIAC_WB_BYPASS_EN
  ,
  output logic                               fwd_hit1,
  output logic                               fwd_hit2,
  output logic [REG_DATA_WIDTH-1:0]          fwd_data1,
  output logic [REG_DATA_WIDTH-1:0]          fwd_data2
`endif
);

  localparam int GW   = $clog2(NUM_REQ);
  localparam int NREG = 1 << REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = REG_ADDR_WIDTH'(REG_ZERO);

  logic [NUM_REQ-1:0]        grant;
  logic [GW-1:0]             last_grant;
  logic [GW-1:0]             grant_idx;
  logic [REG_ADDR_WIDTH-1:0] sel_addr;
  logic [REG_DATA_WIDTH-1:0] sel_data;
  logic                      handshake;
  logic [NREG-1:0]           busy;

  ceyloniac_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign req_ready = grant;
  assign handshake = |grant;

  always_comb begin
    sel_addr  = '0;
    sel_data  = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        sel_data  = req_data[i*REG_DATA_WIDTH +: REG_DATA_WIDTH];
        grant_idx = GW'(i);
      end
    end
  end

  // Register 0 still completes its handshake but never reaches the file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant      <= GW'(NUM_REQ - 1);
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
    end else if (handshake) begin
      last_grant      <= grant_idx;
      rf_write_enable <= (sel_addr != ZERO_ADDR);
      rf_write_addr   <= sel_addr;
      rf_write_data   <= sel_data;
    end else begin
      rf_write_enable <= 1'b0;
    end
  end

  // Reserve is applied after the commit clear so a new producer wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (handshake) busy[sel_addr] <= 1'b0;
      if (rsv_valid && (rsv_addr != ZERO_ADDR)) busy[rsv_addr] <= 1'b1;
    end
  end

`ifdef CEYLONIAC_WB_BYPASS_EN
  assign fwd_hit1    = rf_write_enable && (rf_write_addr == query_addr1) && (query_addr1 != ZERO_ADDR);
  assign fwd_hit2    = rf_write_enable && (rf_write_addr == query_addr2) && (query_addr2 != ZERO_ADDR);
  assign fwd_data1   = rf_write_data;
  assign fwd_data2   = rf_write_data;
  assign query_busy1 = busy[query_addr1] && (query_addr1 != ZERO_ADDR) && !fwd_hit1;
  assign query_busy2 = busy[query_addr2] && (query_addr2 != ZERO_ADDR) && !fwd_hit2;
`else
  assign query_busy1 = busy[query_addr1] && (query_addr1 != ZERO_ADDR);
  assign query_busy2 = busy[query_addr2] && (query_addr2 != ZERO_ADDR);
`endif

endmodule
